// File: rtl/lifo_stack_ctrl_if.sv
// Bus bundle for lifo_stack_ctrl: request side (clear/push/pop/data) and
// status side (data path, occupancy and flags).
interface lifo_stack_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, push, pop, data_in,
    input  data_out, data_valid, top, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  clear, push, pop, data_in,
    output data_out, data_valid, top, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack with peek, replace-top on simultaneous push/pop,
// threshold flags and sticky overflow/underflow errors.
module lifo_stack_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  lifo_stack_ctrl_if.slave     bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] data_out_r;
  logic             data_valid_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             full_s;
  logic             empty_s;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic [AW-1:0]    top_idx_s;
  logic [AW-1:0]    wr_idx_s;
  logic [WIDTH-1:0] top_s;

  // Accept decisions, write index and top-of-stack peek, all from registered state
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    empty_s   = (count_r == {CW{1'b0}});
    pop_ok_s  = bus.pop & ~empty_s;
    push_ok_s = bus.push & (~full_s | pop_ok_s);
    top_idx_s = AW'(count_r - CW'(1));
    // A replace overwrites the current top instead of the next free slot
    if (pop_ok_s) begin
      wr_idx_s = top_idx_s;
    end else begin
      wr_idx_s = AW'(count_r);
    end
    if (empty_s) begin
      top_s = {WIDTH{1'b0}};
    end else begin
      top_s = mem_r[top_idx_s];
    end
  end

  // Storage array; intentionally not reset
  always_ff @(posedge clk) begin
    if (push_ok_s && !bus.clear && !reset) begin
      mem_r[wr_idx_s] <= bus.data_in;
    end
  end

  // Occupancy, popped-data register and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r      <= {CW{1'b0}};
      data_out_r   <= {WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else if (bus.clear) begin
      count_r      <= {CW{1'b0}};
      data_out_r   <= {WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      data_valid_r <= pop_ok_s;
      if (pop_ok_s) begin
        data_out_r <= top_s;
      end
      if (bus.push && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.pop && !pop_ok_s) begin
        underflow_r <= 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.count        = count_r;
  assign bus.data_out     = data_out_r;
  assign bus.data_valid   = data_valid_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
  assign bus.top          = top_s;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_r >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_r <= CW'(AE_THRESH));
endmodule
